// File: rtl/sigma_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sigma_mem_pkg
// Brief   : Shared constants and types for the Sigma-7 memory arbiter.
// Revision: 1.0
// ============================================================================
package sigma_mem_pkg;

    localparam int c_ADDR_MSB = 15;
    localparam int c_ADDR_LSB = 31;
    localparam int c_DATA_W   = 32;
    localparam int c_BE_W     = 4;

    localparam int         c_STATE_W   = 2;
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACCESS  = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;

    localparam logic c_REQ_CPU = 1'b0;
    localparam logic c_REQ_IOP = 1'b1;

    // Sigma numbering: bit 0 is the most significant bit.
    typedef logic [c_ADDR_MSB:c_ADDR_LSB] addr_t;
    typedef logic [0:c_DATA_W-1]          data_t;
    typedef logic [0:c_BE_W-1]            be_t;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : memory_arbiter_if
// Brief   : CPU/IOP request ports and memory port of the arbiter.
// Revision: 1.0
// ============================================================================
interface memory_arbiter_if;
    import sigma_mem_pkg::*;

    logic  cpu_req;
    logic  cpu_lock;
    addr_t cpu_address;
    data_t cpu_data_out;
    be_t   cpu_wr_enables;
    logic  cpu_ack;
    data_t cpu_data_in;

    logic  iop_req;
    logic  iop_lock;
    addr_t iop_address;
    data_t iop_data_out;
    be_t   iop_wr_enables;
    logic  iop_ack;
    data_t iop_data_in;

    addr_t mem_address;
    data_t mem_data_out;
    be_t   mem_wr_enables;
    data_t mem_data_in;

    modport slave (
        input  cpu_req, cpu_lock, cpu_address, cpu_data_out, cpu_wr_enables,
        output cpu_ack, cpu_data_in,
        input  iop_req, iop_lock, iop_address, iop_data_out, iop_wr_enables,
        output iop_ack, iop_data_in,
        output mem_address, mem_data_out, mem_wr_enables,
        input  mem_data_in
    );

    modport master (
        output cpu_req, cpu_lock, cpu_address, cpu_data_out, cpu_wr_enables,
        input  cpu_ack, cpu_data_in,
        output iop_req, iop_lock, iop_address, iop_data_out, iop_wr_enables,
        input  iop_ack, iop_data_in,
        input  mem_address, mem_data_out, mem_wr_enables,
        output mem_data_in
    );

endinterface
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module  : arb_rr2
// Brief   : Combinational 2-way round-robin pick with lock override.
// Revision: 1.0
// ============================================================================
module arb_rr2
    import sigma_mem_pkg::*;
(
    input  wire logic [1:0] req,
    input  wire logic       last,
    input  wire logic       lock_hold,
    output logic            winner
);

    always_comb begin
        winner = c_REQ_CPU;
        if (lock_hold && req[last]) begin
            winner = last;
        end else if (req[0] && req[1]) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = c_REQ_IOP;
        end else begin
            winner = c_REQ_CPU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : memory_arbiter
// Brief   : Shares one synchronous memory port between the CPU and the IOP.
// Revision: 1.0
// ============================================================================
module memory_arbiter
    import sigma_mem_pkg::*;
#(
    parameter int LOCK_LIMIT = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    memory_arbiter_if.slave bus
);

    localparam int                 c_CNT_W = $clog2(LOCK_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(LOCK_LIMIT);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;

    logic               r_owner;
    logic               r_last;
    logic [c_CNT_W-1:0] r_lock_cnt;
    addr_t              r_mem_address;
    data_t              r_mem_data_out;
    be_t                r_mem_wr_enables;
    logic               r_cpu_ack;
    logic               r_iop_ack;
    data_t              r_cpu_data_in;
    data_t              r_iop_data_in;

    logic [1:0] w_req;
    logic       w_in_ack;
    logic       w_owner_lock;
    logic       w_lock_hold;
    logic       w_locked;
    logic       w_other_waiting;
    logic       w_winner;
    logic       w_grant;
    logic       w_access;
    logic       w_capture;
    addr_t      w_sel_address;
    data_t      w_sel_data;
    be_t        w_sel_we;

    assign w_req           = {bus.iop_req, bus.cpu_req};
    assign w_in_ack        = r_cpu_ack | r_iop_ack;
    assign w_owner_lock    = (r_owner == c_REQ_CPU) ? bus.cpu_lock : bus.iop_lock;
    // Lock is only honoured in the owner's ack cycle and only below the limit.
    assign w_lock_hold     = w_in_ack && w_owner_lock && (r_lock_cnt < c_LIMIT);
    assign w_locked        = w_lock_hold && w_req[r_last];
    assign w_other_waiting = w_req[~r_last];

    arb_rr2 u_arb_rr2 (
        .req       (w_req),
        .last      (r_last),
        .lock_hold (w_lock_hold),
        .winner    (w_winner)
    );

    assign w_sel_address = (w_winner == c_REQ_IOP) ? bus.iop_address    : bus.cpu_address;
    assign w_sel_data    = (w_winner == c_REQ_IOP) ? bus.iop_data_out   : bus.cpu_data_out;
    assign w_sel_we      = (w_winner == c_REQ_IOP) ? bus.iop_wr_enables : bus.cpu_wr_enables;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:    w_next_state = (|w_req) ? c_ST_ACCESS : c_ST_IDLE;
            c_ST_ACCESS:  w_next_state = c_ST_CAPTURE;
            c_ST_CAPTURE: w_next_state = c_ST_IDLE;
            default:      w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_grant   = 1'b0;
        w_access  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            c_ST_IDLE:    w_grant   = |w_req;
            c_ST_ACCESS:  w_access  = 1'b1;
            c_ST_CAPTURE: w_capture = 1'b1;
            default:      w_grant   = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner          <= c_REQ_CPU;
            r_last           <= c_REQ_IOP;
            r_lock_cnt       <= '0;
            r_mem_address    <= '0;
            r_mem_data_out   <= '0;
            r_mem_wr_enables <= '0;
            r_cpu_ack        <= 1'b0;
            r_iop_ack        <= 1'b0;
            r_cpu_data_in    <= '0;
            r_iop_data_in    <= '0;
        end else begin
            r_cpu_ack <= w_capture && (r_owner == c_REQ_CPU);
            r_iop_ack <= w_capture && (r_owner == c_REQ_IOP);

            if (w_grant) begin
                r_owner          <= w_winner;
                r_last           <= w_winner;
                r_mem_address    <= w_sel_address;
                r_mem_data_out   <= w_sel_data;
                r_mem_wr_enables <= w_sel_we;
                if (w_locked) begin
                    if (w_other_waiting) begin
                        r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
                    end
                end else begin
                    r_lock_cnt <= '0;
                end
            end

            // Strobes drop after the single cycle memory samples them.
            if (w_access) begin
                r_mem_wr_enables <= '0;
            end

            if (w_capture) begin
                if (r_owner == c_REQ_CPU) begin
                    r_cpu_data_in <= bus.mem_data_in;
                end else begin
                    r_iop_data_in <= bus.mem_data_in;
                end
            end
        end
    end

    assign bus.mem_address    = r_mem_address;
    assign bus.mem_data_out   = r_mem_data_out;
    assign bus.mem_wr_enables = r_mem_wr_enables;
    assign bus.cpu_ack        = r_cpu_ack;
    assign bus.iop_ack        = r_iop_ack;
    assign bus.cpu_data_in    = r_cpu_data_in;
    assign bus.iop_data_in    = r_iop_data_in;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_arbiter
// Brief   : Scoreboard bench for memory_arbiter with a byte-lane memory model.
// Revision: 1.0
// ============================================================================
module tb_memory_arbiter;

    typedef struct {
        logic [31:0] data;
        bit          chk;
        int          cyc;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc    = 0;
    int   nerr   = 0;
    int   nchk   = 0;
    int   we_cnt = 0;

    exp_t exp_cpu[$];
    exp_t exp_iop[$];

    logic [0:31] mem [0:1023];

    memory_arbiter_if bus ();

    memory_arbiter #(.LOCK_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [0:31] init_word(input int i);
        return (i == 256) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
    endfunction

    // One-cycle read latency, byte-lane writes on the cycle strobes are up.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            bus.mem_data_in <= '0;
        end else begin
            bus.mem_data_in <= mem[bus.mem_address[22:31]];
            for (int k = 0; k < 4; k++) begin
                if (bus.mem_wr_enables[k])
                    mem[bus.mem_address[22:31]][8*k +: 8] <= bus.mem_data_out[8*k +: 8];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus.mem_wr_enables != '0) we_cnt++;
        if (bus.cpu_ack || bus.iop_ack)
            check("ack_exclusive", 32'(bus.cpu_ack & bus.iop_ack), 32'h0);
        if (bus.cpu_ack) begin
            if (exp_cpu.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL cpu_ack_unexpected: got ack at cycle %0d, required none", cyc);
            end else begin
                e = exp_cpu.pop_front();
                check("cpu_ack_cycle", 32'(cyc), 32'(e.cyc));
                if (e.chk) check("cpu_data_in", bus.cpu_data_in, e.data);
            end
        end
        if (bus.iop_ack) begin
            if (exp_iop.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL iop_ack_unexpected: got ack at cycle %0d, required none", cyc);
            end else begin
                e = exp_iop.pop_front();
                check("iop_ack_cycle", 32'(cyc), 32'(e.cyc));
                if (e.chk) check("iop_data_in", bus.iop_data_in, e.data);
            end
        end
    end

    // Called on a falling edge; returns on the falling edge of the ack cycle.
    task automatic issue(input bit who, input logic [16:0] a, input logic [31:0] wd,
                         input logic [3:0] we, input bit lk, input bit chk,
                         input logic [31:0] ed, input int ecyc, input bit hold);
        exp_t e;
        bit   got;
        e.data = ed; e.chk = chk; e.cyc = ecyc;
        if (who == 1'b0) begin
            bus.cpu_address = a; bus.cpu_data_out = wd; bus.cpu_wr_enables = we;
            bus.cpu_lock = lk; bus.cpu_req = 1'b1;
            exp_cpu.push_back(e);
        end else begin
            bus.iop_address = a; bus.iop_data_out = wd; bus.iop_wr_enables = we;
            bus.iop_lock = lk; bus.iop_req = 1'b1;
            exp_iop.push_back(e);
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            got = who ? bus.iop_ack : bus.cpu_ack;
        end
        nchk++;
        if (!got) begin
            nerr++;
            $display("FAIL ack_timeout: requester %0d got no ack, required ack by cycle %0d", who, ecyc);
        end
        if (!hold) begin
            if (who == 1'b0) begin bus.cpu_req = 1'b0; bus.cpu_lock = 1'b0; end
            else             begin bus.iop_req = 1'b0; bus.iop_lock = 1'b0; end
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_lock = 1'b0;
        bus.iop_req = 1'b0; bus.iop_lock = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lk_cyc[6] = '{3, 6, 9, 12, 15, 21};
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_lock = 1'b0; bus.cpu_address = '0;
        bus.cpu_data_out = '0; bus.cpu_wr_enables = '0;
        bus.iop_req = 1'b0; bus.iop_lock = 1'b0; bus.iop_address = '0;
        bus.iop_data_out = '0; bus.iop_wr_enables = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_mem_address", 32'(bus.mem_address), 32'h0);
        check("rst_mem_data_out", bus.mem_data_out, 32'h0);
        check("rst_mem_wr_enables", 32'(bus.mem_wr_enables), 32'h0);
        check("rst_acks", 32'({bus.cpu_ack, bus.iop_ack}), 32'h0);
        check("rst_cpu_data_in", bus.cpu_data_in, 32'h0);
        check("rst_iop_data_in", bus.iop_data_in, 32'h0);

        // CPU read
        t0 = cyc;
        fork
            issue(1'b0, 17'h00100, 32'h0, 4'b0000, 1'b0, 1'b1, 32'hDEADBEEF, t0 + 3, 1'b0);
            begin
                @(negedge clock);
                check("rd_mem_address", 32'(bus.mem_address), 32'h00100);
            end
        join
        check("rd_no_write_strobe", 32'(we_cnt), 32'h0);
        @(negedge clock);

        // IOP byte write, then CPU read-back
        t0 = cyc;
        fork
            issue(1'b1, 17'h00200, 32'h0000AB00, 4'b0010, 1'b0, 1'b0, 32'h0, t0 + 3, 1'b0);
            begin
                @(negedge clock);
                check("wr_mem_address", 32'(bus.mem_address), 32'h00200);
                check("wr_mem_data_out", bus.mem_data_out, 32'h0000AB00);
                check("wr_strobe_access", 32'(bus.mem_wr_enables), 32'h2);
                @(negedge clock);
                check("wr_strobe_capture", 32'(bus.mem_wr_enables), 32'h0);
            end
        join
        check("wr_strobe_cycles", 32'(we_cnt), 32'h1);
        check("cpu_data_in_held", bus.cpu_data_in, 32'hDEADBEEF);
        @(negedge clock);
        t0 = cyc;
        issue(1'b0, 17'h00200, 32'h0, 4'b0000, 1'b0, 1'b1, 32'hA500AB00, t0 + 3, 1'b0);

        // Both requesting from reset: CPU, IOP, CPU, IOP
        do_reset();
        t0 = cyc;
        fork
            begin
                issue(1'b0, 17'h00010, 32'h0, 4'b0, 1'b0, 1'b1, 32'hA5000010, t0 + 3, 1'b1);
                issue(1'b0, 17'h00011, 32'h0, 4'b0, 1'b0, 1'b1, 32'hA5000011, t0 + 9, 1'b0);
            end
            begin
                issue(1'b1, 17'h00020, 32'h0, 4'b0, 1'b0, 1'b1, 32'hA5000020, t0 + 6, 1'b1);
                issue(1'b1, 17'h00021, 32'h0, 4'b0, 1'b0, 1'b1, 32'hA5000021, t0 + 12, 1'b0);
            end
        join

        // CPU lock against a waiting IOP: five CPU grants, then the IOP
        do_reset();
        t0 = cyc;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    issue(1'b0, 17'(32'h40 + k), 32'h0, 4'b0, 1'b1, 1'b1,
                          32'hA5000040 + 32'(k), t0 + lk_cyc[k], k < 5);
            end
            issue(1'b1, 17'h00030, 32'h0, 4'b0, 1'b0, 1'b1, 32'hA5000030, t0 + 18, 1'b0);
        join
        @(negedge clock);

        // Reset lands on the CAPTURE edge of a CPU read
        t0 = cyc;
        bus.cpu_address = 17'h00050; bus.cpu_wr_enables = '0; bus.cpu_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clock);
        check("rstmid_cpu_ack", 32'(bus.cpu_ack), 32'h0);
        check("rstmid_mem_address", 32'(bus.mem_address), 32'h0);
        check("rstmid_cpu_data_in", bus.cpu_data_in, 32'h0);
        check("rstmid_mem_wr_enables", 32'(bus.mem_wr_enables), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("rstmid_no_late_ack", 32'(bus.cpu_ack), 32'h0);
        t0 = cyc;
        issue(1'b0, 17'h00060, 32'h0, 4'b0, 1'b0, 1'b1, 32'hA5000060, t0 + 3, 1'b0);
        repeat (4) @(negedge clock);

        check("cpu_queue_drained", 32'(exp_cpu.size()), 32'h0);
        check("iop_queue_drained", 32'(exp_iop.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
